ifetch32: RTL and testbench
===========================

// Module: ifetch32
// PURPOSE
//  Instruction-fetch stage of the single-cycle MIPS CPU; sits directly upstream of control32 and the decoder.
//  Holds the PC, drives the synchronous instruction-memory read port and presents the instruction aligned with PC.
//  Computes next-PC from control32's Jr/Jmp/Jal/Branch/nBranch flags and the ALU Zero flag, and latches the jal link address.
//  Supports stall and halt/resume for the debug/IO controller.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_ADDR_W 14             word-address width of instruction memory (16K words)
// PORTS
//  clock         in   1   system clock, all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  imem_addr     out  14  word address to instruction BRAM (registered-output BRAM, 1-cycle read)
//  imem_rdata    in   32  BRAM data, valid the cycle after imem_addr is sampled
//  Instruction   out  32  current instruction (= imem_rdata) for control32/decoder
//  instr_valid   out  1   1 = Instruction may commit this cycle
//  pc            out  32  address of current Instruction
//  branch_base_addr out 32  pc+4 (for ALU branch-address adder)
//  link_addr     out  32  pc+4 of the last committed jal
//  Branch,nBranch,Jmp,Jal,Jr in 1 each  from control32
//  Zero          in   1   ALU zero flag
//  Read_data_1   in   32  rs value (jr target)
//  stall         in   1   hold PC, suppress commit
//  halt_req      in   1   halt after committing current instruction
//  resume        in   1   leave HALT
//  addr_err      out  1   sticky: misaligned jr target or fetch beyond IMEM range
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, state=BOOT, link_addr=0, addr_err=0, instr_valid=0; takes effect immediately, mid-instruction included.
//  FSM states BOOT, RUN, HALT.
//   BOOT: imem_addr=RESET_PC[IMEM_ADDR_W+1:2]; instr_valid=0; pc held; next edge -> RUN.
//   RUN : instr_valid = ~stall. commit = ~stall.
//         commit: pc<=next_pc; imem_addr=next_pc word index (combinational) so BRAM data aligns with new pc.
//         stall : pc held; imem_addr=pc word index; halt_req ignored (requester holds it).
//         commit & halt_req -> HALT.
//   HALT: instr_valid=0; pc held; imem_addr=pc; resume -> RUN next edge (instruction already valid).
//         halt_req & resume together in HALT: resume wins.
//  next_pc priority (32-bit, wraps mod 2^32):
//   1 Jr: {Read_data_1[31:2],2'b00}; if Read_data_1[1:0]!=0 set addr_err.
//   2 Jmp|Jal: {pc_plus4[31:28], Instruction[25:0], 2'b00}.
//   3 (Branch&Zero)|(nBranch&~Zero): pc_plus4 + {{14{Instruction[15]}},Instruction[15:0],2'b00}.
//   4 else pc_plus4 = pc+4 (0xFFFF_FFFC -> 0x0000_0000).
//  link_addr <= pc_plus4 on commit with Jal; otherwise held.
//  addr_err also set on commit when next_pc[31:IMEM_ADDR_W+2]!=0; imem_addr uses low bits regardless.
//  addr_err cleared only by reset; does not stop fetch.
//  branch_base_addr = pc+4 combinationally, all states.
//  Instruction = imem_rdata unmodified; consumers must gate state writes with instr_valid.
// TESTING
//  Reset released, imem word0=0x2008_0005 -> BOOT 1 cycle instr_valid=0, then pc=0, Instruction=0x2008_0005, instr_valid=1.
//  Straight-line fetch of 4 NOPs from 0 -> pc 0,4,8,C on consecutive cycles; imem_addr leads pc by one cycle.
//  beq at pc=0x20, imm=0xFFFF, Zero=1 -> next pc=0x20; same with Zero=0 -> 0x24; bne inverse.
//  jal at pc=0x10, instr_index=0x40 -> pc=0x100, link_addr=0x14; jr Read_data_1=0x103 -> pc=0x100, addr_err=1.
//  stall 3 cycles at pc=0x8 -> pc held, instr_valid=0; halt_req at pc=0xC -> pc=0x10 then HALT; resume -> RUN, pc=0x10 valid.
//  RESET_PC=0xFFFF_FFFC, one commit -> pc=0x0000_0000; reset_n pulsed mid-RUN -> pc=RESET_PC, BOOT immediately.

Source files
------------

// File: rtl/ifetch32.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction BRAM and
// selects the next PC from the jump/branch flags, with stall and debug halt/resume.
module ifetch32 #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            Instruction,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            branch_base_addr,
    output logic [31:0]            link_addr,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jr,
    input  logic                   Zero,
    input  logic [31:0]            Read_data_1,
    input  logic                   stall,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic                   addr_err
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic        err_q, err_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] br_off_s;
    logic [31:0] next_pc_s;
    logic        take_branch_s;
    logic        commit_s;
    logic        jr_err_s;
    logic        range_err_s;

    assign Instruction      = imem_rdata;
    assign pc_plus4_s       = pc_q + 32'd4;
    assign branch_base_addr = pc_plus4_s;
    assign take_branch_s    = (Branch & Zero) | (nBranch & ~Zero);
    assign br_off_s         = {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
    assign commit_s         = (state_q == ST_RUN) & ~stall;
    assign jr_err_s         = Jr & (Read_data_1[1:0] != 2'b00);
    assign range_err_s      = (next_pc_s[31:IMEM_ADDR_W+2] != '0);

    assign instr_valid = commit_s;
    assign pc          = pc_q;
    assign link_addr   = link_q;
    assign addr_err    = err_q;

    // Next-PC selection: jr > jmp/jal > taken branch > sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (Jr) begin
            next_pc_s = {Read_data_1[31:2], 2'b00};
        end else if (Jmp | Jal) begin
            next_pc_s = {pc_plus4_s[31:28], imem_rdata[25:0], 2'b00};
        end else if (take_branch_s) begin
            next_pc_s = pc_plus4_s + br_off_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // BRAM address leads the PC on commit so the read data lines up with the new PC.
    always_comb begin
        imem_addr = pc_q[IMEM_ADDR_W+1:2];
        case (state_q)
            ST_BOOT: imem_addr = RESET_PC[IMEM_ADDR_W+1:2];
            ST_RUN: begin
                if (commit_s) begin
                    imem_addr = next_pc_s[IMEM_ADDR_W+1:2];
                end else begin
                    imem_addr = pc_q[IMEM_ADDR_W+1:2];
                end
            end
            ST_HALT: imem_addr = pc_q[IMEM_ADDR_W+1:2];
            default: imem_addr = pc_q[IMEM_ADDR_W+1:2];
        endcase
    end

    // FSM and architectural next-state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
        err_d   = err_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (commit_s) begin
                    pc_d = next_pc_s;
                    if (Jal) begin
                        link_d = pc_plus4_s;
                    end else begin
                        link_d = link_q;
                    end
                    if (jr_err_s | range_err_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            link_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32: a vector table walks a small program through a BRAM model,
// then a second instance with RESET_PC=0xFFFF_FFFC covers wrap, range error and async reset.
module tb_ifetch32;

    typedef struct {
        logic        jr, jmp, jal, br, nbr, zero;
        logic [31:0] rd1;
        logic        stall, halt, resume;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [13:0] addr;
        logic [31:0] link;
        logic        err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [13:0] a_addr;
    logic [31:0] a_rdata, a_instr, a_pc, a_bba, a_link;
    logic        a_valid, a_err;
    logic        br, nbr, jmp, jal, jr, zero, stall, halt, resume;
    logic [31:0] rd1;

    logic        b_rst_n;
    logic [13:0] b_addr;
    logic [31:0] b_instr, b_pc, b_bba, b_link;
    logic        b_valid, b_err, b_jr;
    logic [31:0] b_rd1;

    logic [31:0] mem [256];
    vec_t        vecs [23];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    always @(posedge clock) a_rdata <= mem[a_addr[7:0]];

    ifetch32 u_a (
        .clock(clock), .reset_n(reset_n), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .Instruction(a_instr), .instr_valid(a_valid), .pc(a_pc), .branch_base_addr(a_bba),
        .link_addr(a_link), .Branch(br), .nBranch(nbr), .Jmp(jmp), .Jal(jal), .Jr(jr),
        .Zero(zero), .Read_data_1(rd1), .stall(stall), .halt_req(halt), .resume(resume),
        .addr_err(a_err)
    );

    ifetch32 #(.RESET_PC(32'hFFFF_FFFC), .IMEM_ADDR_W(14)) u_b (
        .clock(clock), .reset_n(b_rst_n), .imem_addr(b_addr), .imem_rdata(32'h0000_0000),
        .Instruction(b_instr), .instr_valid(b_valid), .pc(b_pc), .branch_base_addr(b_bba),
        .link_addr(b_link), .Branch(1'b0), .nBranch(1'b0), .Jmp(1'b0), .Jal(1'b0), .Jr(b_jr),
        .Zero(1'b0), .Read_data_1(b_rd1), .stall(1'b0), .halt_req(1'b0), .resume(1'b0),
        .addr_err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] fl, input logic [31:0] r, input logic [2:0] ctl,
                                input logic [31:0] p, input logic v, input logic [31:0] ins,
                                input logic [13:0] ad, input logic [31:0] lk, input logic e);
        vec_t t;
        {t.jr, t.jmp, t.jal, t.br, t.nbr, t.zero} = fl;
        t.rd1 = r;
        {t.stall, t.halt, t.resume} = ctl;
        t.pc = p; t.valid = v; t.instr = ins; t.addr = ad; t.link = lk; t.err = e;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[0]    = 32'h2008_0005;
        mem[4]    = 32'h0C00_0040;   // jal 0x100
        mem[8]    = 32'h1000_FFFF;   // beq -1
        mem[9]    = 32'h1400_FFFF;   // bne -1
        mem[8'h40] = 32'h03E0_0008;  // jr
        mem[8'h41] = 32'h0800_0008;  // j 0x20
        mem[8'h80] = 32'h0800_0006;  // j 0x18

        //               jr jmp jal br nbr z   rd1            st ha re  pc            v  instr          addr     link          err
        vecs[0]  = mk(6'b000000, 32'h0,    3'b000, 32'h0,   1'b0, 32'h2008_0005, 14'h000, 32'h0,  1'b0);
        vecs[1]  = mk(6'b000000, 32'h0,    3'b000, 32'h0,   1'b1, 32'h2008_0005, 14'h001, 32'h0,  1'b0);
        vecs[2]  = mk(6'b000000, 32'h0,    3'b000, 32'h4,   1'b1, 32'h0,         14'h002, 32'h0,  1'b0);
        vecs[3]  = mk(6'b000000, 32'h0,    3'b100, 32'h8,   1'b0, 32'h0,         14'h002, 32'h0,  1'b0);
        vecs[4]  = mk(6'b000000, 32'h0,    3'b100, 32'h8,   1'b0, 32'h0,         14'h002, 32'h0,  1'b0);
        vecs[5]  = mk(6'b000000, 32'h0,    3'b110, 32'h8,   1'b0, 32'h0,         14'h002, 32'h0,  1'b0);
        vecs[6]  = mk(6'b000000, 32'h0,    3'b000, 32'h8,   1'b1, 32'h0,         14'h003, 32'h0,  1'b0);
        vecs[7]  = mk(6'b000000, 32'h0,    3'b010, 32'hC,   1'b1, 32'h0,         14'h004, 32'h0,  1'b0);
        vecs[8]  = mk(6'b000000, 32'h0,    3'b010, 32'h10,  1'b0, 32'h0C00_0040, 14'h004, 32'h0,  1'b0);
        vecs[9]  = mk(6'b000000, 32'h0,    3'b011, 32'h10,  1'b0, 32'h0C00_0040, 14'h004, 32'h0,  1'b0);
        vecs[10] = mk(6'b001000, 32'h0,    3'b000, 32'h10,  1'b1, 32'h0C00_0040, 14'h040, 32'h0,  1'b0);
        vecs[11] = mk(6'b100000, 32'h103,  3'b000, 32'h100, 1'b1, 32'h03E0_0008, 14'h040, 32'h14, 1'b0);
        vecs[12] = mk(6'b000000, 32'h0,    3'b000, 32'h100, 1'b1, 32'h03E0_0008, 14'h041, 32'h14, 1'b1);
        vecs[13] = mk(6'b010000, 32'h0,    3'b000, 32'h104, 1'b1, 32'h0800_0008, 14'h008, 32'h14, 1'b1);
        vecs[14] = mk(6'b000101, 32'h0,    3'b000, 32'h20,  1'b1, 32'h1000_FFFF, 14'h008, 32'h14, 1'b1);
        vecs[15] = mk(6'b000100, 32'h0,    3'b000, 32'h20,  1'b1, 32'h1000_FFFF, 14'h009, 32'h14, 1'b1);
        vecs[16] = mk(6'b000010, 32'h0,    3'b000, 32'h24,  1'b1, 32'h1400_FFFF, 14'h009, 32'h14, 1'b1);
        vecs[17] = mk(6'b000011, 32'h0,    3'b000, 32'h24,  1'b1, 32'h1400_FFFF, 14'h00A, 32'h14, 1'b1);
        vecs[18] = mk(6'b110101, 32'h200,  3'b000, 32'h28,  1'b1, 32'h0,         14'h080, 32'h14, 1'b1);
        vecs[19] = mk(6'b010101, 32'h0,    3'b000, 32'h200, 1'b1, 32'h0800_0006, 14'h006, 32'h14, 1'b1);
        vecs[20] = mk(6'b001000, 32'h0,    3'b100, 32'h18,  1'b0, 32'h0,         14'h006, 32'h14, 1'b1);
        vecs[21] = mk(6'b000000, 32'h0,    3'b000, 32'h18,  1'b1, 32'h0,         14'h007, 32'h14, 1'b1);
        vecs[22] = mk(6'b000000, 32'h0,    3'b000, 32'h1C,  1'b1, 32'h0,         14'h008, 32'h14, 1'b1);

        {jr, jmp, jal, br, nbr, zero, stall, halt, resume} = 9'b0;
        rd1 = 32'h0; reset_n = 1'b0; b_rst_n = 1'b0; b_jr = 1'b0; b_rd1 = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset pc", a_pc, 32'h0);
        chk("reset valid", {31'h0, a_valid}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge clock);
            {jr, jmp, jal, br, nbr, zero} = {vecs[i].jr, vecs[i].jmp, vecs[i].jal,
                                             vecs[i].br, vecs[i].nbr, vecs[i].zero};
            rd1 = vecs[i].rd1;
            {stall, halt, resume} = {vecs[i].stall, vecs[i].halt, vecs[i].resume};
            #1;
            chk($sformatf("row%0d pc", i), a_pc, vecs[i].pc);
            chk($sformatf("row%0d valid", i), {31'h0, a_valid}, {31'h0, vecs[i].valid});
            chk($sformatf("row%0d instr", i), a_instr, vecs[i].instr);
            chk($sformatf("row%0d imem_addr", i), {18'h0, a_addr}, {18'h0, vecs[i].addr});
            chk($sformatf("row%0d link", i), a_link, vecs[i].link);
            chk($sformatf("row%0d addr_err", i), {31'h0, a_err}, {31'h0, vecs[i].err});
            chk($sformatf("row%0d bba", i), a_bba, vecs[i].pc + 32'd4);
        end

        // Asynchronous reset in the middle of a cycle.
        {jr, jmp, jal, br, nbr, zero, stall, halt, resume} = 9'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midreset pc", a_pc, 32'h0);
        chk("midreset valid", {31'h0, a_valid}, 32'h0);
        chk("midreset link", a_link, 32'h0);
        chk("midreset err", {31'h0, a_err}, 32'h0);
        chk("midreset addr", {18'h0, a_addr}, 32'h0);

        // Second instance: PC wrap, out-of-range fetch, async reset back to BOOT.
        @(negedge clock);
        b_rst_n = 1'b1;
        #1;
        chk("b boot pc", b_pc, 32'hFFFF_FFFC);
        chk("b boot valid", {31'h0, b_valid}, 32'h0);
        chk("b boot addr", {18'h0, b_addr}, 32'h0000_3FFF);
        chk("b boot bba", b_bba, 32'h0);
        @(negedge clock); #1;
        chk("b run pc", b_pc, 32'hFFFF_FFFC);
        chk("b run valid", {31'h0, b_valid}, 32'h1);
        chk("b run addr", {18'h0, b_addr}, 32'h0);
        @(negedge clock);
        b_jr = 1'b1; b_rd1 = 32'h0001_0000;
        #1;
        chk("b wrap pc", b_pc, 32'h0);
        chk("b wrap err", {31'h0, b_err}, 32'h0);
        chk("b jr addr", {18'h0, b_addr}, 32'h0);
        @(negedge clock);
        b_jr = 1'b0;
        #1;
        chk("b range pc", b_pc, 32'h0001_0000);
        chk("b range err", {31'h0, b_err}, 32'h1);
        chk("b range addr", {18'h0, b_addr}, 32'h0000_0001);
        #2 b_rst_n = 1'b0;
        #1;
        chk("b midreset pc", b_pc, 32'hFFFF_FFFC);
        chk("b midreset valid", {31'h0, b_valid}, 32'h0);
        chk("b midreset err", {31'h0, b_err}, 32'h0);
        chk("b midreset addr", {18'h0, b_addr}, 32'h0000_3FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
